// File: rtl/complex_acc_pkg.sv
// Shared definitions for the complex accumulator sequencing controller:
// controller state encoding and default datapath widths.
package complex_acc_pkg;

  localparam int DEF_ACC_W = 20;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_ACCUM,
    ST_FLUSH,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/term_counter.sv
// Counts accepted product terms for the current job and flags the increment
// that will bring the count up to the latched job length.
module term_counter
  import complex_acc_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] target,
  output logic             last
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_inc;

  assign count_inc = count_q + CNT_W'(1);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc) begin
      count_q <= count_inc;
    end
  end

  // Jobs never exceed 2^CNT_W-1 terms, so count_inc cannot wrap past target.
  assign last = (count_inc == target);

endmodule

// File: rtl/complex_acc_ctrl.sv
// Sequencing controller for the complex multiplier's real/imaginary accumulators.
// Optional `define COMPLEX_ACC_ABORT_EN adds an abort input that cancels a running job.
module complex_acc_ctrl
  import complex_acc_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_terms,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             acc_init,
  output logic             acc_en,
  input  logic [ACC_W-1:0] acc_re,
  input  logic [ACC_W-1:0] acc_im,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_re,
  output logic [ACC_W-1:0] out_im
`ifdef COMPLEX_ACC_ABORT_EN
  ,
  input  logic             abort
`endif
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] terms_q;
  logic             latch_terms;
  logic             cnt_clr;
  logic             cnt_last;
  logic             capture;
  logic             kill;

`ifdef COMPLEX_ACC_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif

  term_counter #(.CNT_W(CNT_W)) u_term_counter (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .inc    (acc_en),
    .target (terms_q),
    .last   (cnt_last)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    busy        = 1'b1;
    in_ready    = 1'b0;
    acc_init    = 1'b0;
    acc_en      = 1'b0;
    out_valid   = 1'b0;
    cnt_clr     = 1'b0;
    capture     = 1'b0;
    latch_terms = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          latch_terms = 1'b1;
          state_d     = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        acc_init = 1'b1;
        cnt_clr  = 1'b1;
        if (kill)                state_d = ST_IDLE;
        else if (terms_q == '0)  state_d = ST_FLUSH;
        else                     state_d = ST_ACCUM;
      end
      ST_ACCUM: begin
        // Dropping ready on abort keeps the upstream from seeing a handshake
        // for a term that is never accumulated.
        in_ready = !kill;
        acc_en   = in_valid & in_ready;
        if (kill)                    state_d = ST_IDLE;
        else if (acc_en && cnt_last) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (kill) begin
          state_d = ST_IDLE;
        end else begin
          capture = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      terms_q <= '0;
      out_re  <= '0;
      out_im  <= '0;
    end else begin
      state_q <= state_d;
      if (latch_terms) terms_q <= num_terms;
      if (capture) begin
        out_re <= acc_re;
        out_im <= acc_im;
      end
    end
  end

endmodule

// File: tb/tb_complex_acc_ctrl.sv
// Randomized self-checking bench for complex_acc_ctrl with a behavioural accumulator
// and a job-level reference model; abort tests run when COMPLEX_ACC_ABORT_EN is defined.
module tb_complex_acc_ctrl;
  import complex_acc_pkg::*;

  localparam int ACC_W = DEF_ACC_W;
  localparam int CNT_W = DEF_CNT_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_terms = '0;
  logic             busy;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             acc_init;
  logic             acc_en;
  logic [ACC_W-1:0] acc_re, acc_im;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] out_re, out_im;
  logic [ACC_W-1:0] term_re = '0, term_im = '0;
`ifdef COMPLEX_ACC_ABORT_EN
  logic             abort = 1'b0;
`endif

  always #5 clk = ~clk;

  complex_acc_ctrl #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_terms (num_terms),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .acc_init  (acc_init),
    .acc_en    (acc_en),
    .acc_re    (acc_re),
    .acc_im    (acc_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im)
`ifdef COMPLEX_ACC_ABORT_EN
    ,
    .abort     (abort)
`endif
  );

  // Behavioural stand-in for the external accumulator registers.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_re <= '0;
      acc_im <= '0;
    end else if (acc_init) begin
      acc_re <= '0;
      acc_im <= '0;
    end else if (acc_en) begin
      acc_re <= acc_re + term_re;
      acc_im <= acc_im + term_im;
    end
  end

  int cyc = 0, init_pulses = 0, en_pulses = 0, overlap = 0;
  always @(posedge clk) begin
    cyc++;
    if (acc_init) init_pulses++;
    if (acc_en) en_pulses++;
    if (acc_init && acc_en) overlap++;
  end

  int n_checks = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Job stimulus: explicit terms/valid pattern first, then random fill.
  logic [ACC_W-1:0] t_re[$], t_im[$];
  int               vpat[$];
  logic [ACC_W-1:0] last_re = '0, last_im = '0;

  task automatic clear_stim();
    t_re.delete();
    t_im.delete();
    vpat.delete();
  endtask

  task automatic start_job(input int n);
    @(negedge clk);
    start     = 1'b1;
    num_terms = CNT_W'(n);
    @(posedge clk);
    @(negedge clk);
    start     = 1'b0;
    num_terms = CNT_W'($urandom);
  endtask

  // Present terms until n valid beats have been offered; returns cycles spent.
  task automatic feed(input string tag, input int n, input int bubble_pct,
                      inout logic [ACC_W-1:0] e_re, inout logic [ACC_W-1:0] e_im,
                      output int c);
    int idx;
    bit v;
    idx = 0;
    c   = 0;
    while (t_re.size() < n) begin
      t_re.push_back(ACC_W'($urandom));
      t_im.push_back(ACC_W'($urandom));
    end
    while (idx < n) begin
      @(negedge clk);
      if (vpat.size() > 0) v = (vpat.pop_front() != 0);
      else                 v = ($urandom_range(99) >= bubble_pct);
      in_valid = v;
      if (v) begin
        term_re = t_re.pop_front();
        term_im = t_im.pop_front();
        e_re += term_re;
        e_im += term_im;
        idx++;
      end else begin
        term_re = ACC_W'($urandom);
        term_im = ACC_W'($urandom);
      end
      #1;
      check({tag, " accum ready"}, in_ready, 1);
      check({tag, " accum en"}, acc_en, v);
      c++;
    end
  endtask

  task automatic run_job(input string tag, input int n, input int bubble_pct,
                         input int hold_cycles, input bit poke_start);
    logic [ACC_W-1:0] e_re, e_im;
    int c, s, lat, i0, en0;
    e_re = '0;
    e_im = '0;
    i0   = init_pulses;
    en0  = en_pulses;
    start_job(n);
    s = cyc;
    in_valid = 1'b1;
    term_re  = ACC_W'($urandom);
    term_im  = ACC_W'($urandom);
    #1;
    check({tag, " clear init"}, acc_init, 1);
    check({tag, " clear en"}, acc_en, 0);
    check({tag, " clear ready"}, in_ready, 0);
    check({tag, " clear busy"}, busy, 1);
    feed(tag, n, bubble_pct, e_re, e_im, c);
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      if (out_valid) begin
        lat = cyc - s;
        break;
      end
    end
    check({tag, " latency"}, lat, c + 2);
    check({tag, " out_re"}, out_re, e_re);
    check({tag, " out_im"}, out_im, e_im);
    check({tag, " init pulses"}, init_pulses - i0, 1);
    check({tag, " en pulses"}, en_pulses - en0, n);
    for (int h = 0; h < hold_cycles; h++) begin
      @(negedge clk);
      out_ready = 1'b0;
      start     = poke_start && (h == 1);
      #1;
      check({tag, " hold valid"}, out_valid, 1);
      check({tag, " hold re"}, out_re, e_re);
      check({tag, " hold im"}, out_im, e_im);
    end
    @(negedge clk);
    out_ready = 1'b1;
    start     = poke_start;
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b0;
    #1;
    check({tag, " idle busy"}, busy, 0);
    check({tag, " idle valid"}, out_valid, 0);
    check({tag, " idle init"}, acc_init, 0);
    last_re = e_re;
    last_im = e_im;
    clear_stim();
  endtask

  task automatic reset_mid_job();
    logic [ACC_W-1:0] e_re, e_im;
    int c;
    e_re = '0;
    e_im = '0;
    clear_stim();
    start_job(5);
    feed("rst_mid", 2, 0, e_re, e_im, c);
    @(negedge clk);
    in_valid = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("rst busy", busy, 0);
    check("rst in_ready", in_ready, 0);
    check("rst acc_init", acc_init, 0);
    check("rst acc_en", acc_en, 0);
    check("rst out_valid", out_valid, 0);
    check("rst out_re", out_re, 0);
    check("rst out_im", out_im, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("rst release busy", busy, 0);
    clear_stim();
  endtask

`ifdef COMPLEX_ACC_ABORT_EN
  task automatic abort_mid_job();
    logic [ACC_W-1:0] e_re, e_im;
    int c;
    e_re = '0;
    e_im = '0;
    clear_stim();
    start_job(5);
    feed("abort", 2, 0, e_re, e_im, c);
    @(negedge clk);
    in_valid = 1'b1;
    abort    = 1'b1;
    #1;
    check("abort en forced", acc_en, 0);
    @(negedge clk);
    abort    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("abort idle", busy, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check("abort no valid", out_valid, 0);
    end
    check("abort keep re", out_re, last_re);
    check("abort keep im", out_im, last_im);
    clear_stim();
  endtask
`endif

  initial begin
    #1 rst = 1'b0;
    #1;
    check("reset busy", busy, 0);
    check("reset in_ready", in_ready, 0);
    check("reset acc_init", acc_init, 0);
    check("reset acc_en", acc_en, 0);
    check("reset out_valid", out_valid, 0);
    check("reset out_re", out_re, 0);
    check("reset out_im", out_im, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Three back-to-back terms: (1+2i) + (3-1i) + (-2+4i) = 2+5i.
    clear_stim();
    t_re = '{ACC_W'(1), ACC_W'(3), ACC_W'(-2)};
    t_im = '{ACC_W'(2), ACC_W'(-1), ACC_W'(4)};
    run_job("n3", 3, 0, 0, 1'b0);
    check("n3 direct re", out_re, 2);
    check("n3 direct im", out_im, 5);

    vpat = '{1, 0, 0, 1, 1, 0, 1};
    run_job("n4 bubbles", 4, 0, 0, 1'b0);

    run_job("n0", 0, 0, 0, 1'b0);
    check("n0 result re", last_re, 0);

    run_job("hold stall", 3, 20, 5, 1'b1);

    reset_mid_job();
    run_job("post rst", 5, 0, 1, 1'b0);

`ifdef COMPLEX_ACC_ABORT_EN
    abort_mid_job();
    run_job("post abort", 2, 30, 0, 1'b0);
`endif

    for (int j = 0; j < 8; j++) begin
      run_job($sformatf("rand%0d", j), $urandom_range(12), $urandom_range(50),
              $urandom_range(3), 1'($urandom_range(1)));
    end

    check("init/en overlap", overlap, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
